ime_sad_16x16_buffer_ctrl: RTL and testbench
============================================

// Module: ime_sad_16x16_buffer_ctrl
// PURPOSE
//  Sequencer for the three-bank 16x16 SAD buffer (three 32-entry rf_1p banks, each 4 SADs wide).
//  WRITE phase: steers each 4-SAD beat from the SAD tree into bank 0, then bank 1, then bank 2
//  (addresses 0..31 in each bank). READ phase: sweeps addresses 0..31 so that all three banks
//  present their words together to the downstream cost/decision stage, using a valid/ready handshake.
// PARAMETERS
//  DEPTH    32  entries per bank; power of 2
//  BLOCKS   3   number of banks written in sequence; range 1..4
//  ADDR_W   5   address width; equals log2(DEPTH)
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  start_i      in   1       1-cycle pulse; starts a frame of BLOCKS*DEPTH writes then DEPTH reads
//  sad_valid_i  in   1       SAD-tree beat valid; x0..x3 data goes directly to the banks
//  addr_o       out  ADDR_W  bank address; drives addr_i of all banks
//  wren_o       out  1       write enable; drives wren_i of all banks
//  block_o      out  2       bank select for the write; drives block_i
//  rd_valid_o   out  1       bank outputs hold a valid word for rd_idx_o
//  rd_ready_i   in   1       consumer accepts the word
//  rd_idx_o     out  ADDR_W  index of the word currently on the bank outputs
//  rd_last_o    out  1       rd_valid_o && rd_idx_o==DEPTH-1
//  busy_o       out  1       state != IDLE
//  done_o       out  1       1-cycle pulse when the frame completes
//  err_o        out  1       sticky; set when sad_valid_i arrives outside WRITE; cleared by start_i or rst
// BEHAVIOUR
//  Reset: state=IDLE; wr_idx=0, wr_blk=0, rd_idx=0; rd_valid_o=0, done_o=0, err_o=0.
//   Combinational outputs in IDLE: addr_o=0, wren_o=0, block_o=0.
//  States: IDLE -> WRITE -> READ -> DONE -> IDLE.
//  IDLE:  start_i -> WRITE. Clears err_o and all counters. start_i is ignored in every other state.
//  WRITE: wren_o = sad_valid_i (combinational, same cycle as the data). addr_o=wr_idx, block_o=wr_blk.
//   Each beat increments wr_idx. When wr_idx wraps from DEPTH-1 to 0, wr_blk increments.
//   The beat at wr_blk==BLOCKS-1, wr_idx==DEPTH-1 moves the FSM to READ the next cycle.
//   Gaps between beats are allowed; addr_o and block_o hold during a gap.
//  READ:  wren_o=0, block_o=0. The banks have a 1-cycle registered read.
//   On entry, addr_o=0. rd_valid_o rises 1 cycle after entry, with rd_idx_o=0.
//   Handshake: hs = rd_valid_o && rd_ready_i.
//   addr_o = hs ? rd_idx+1 : rd_idx (combinational lookahead). This gives 1 word/cycle when
//   ready is held high. When ready is low, the address is held and the bank output stays stable.
//   rd_valid_o and rd_idx_o must not change while rd_valid_o=1 and rd_ready_i=0.
//   hs with rd_idx==DEPTH-1: rd_valid_o goes low next cycle and the FSM moves to DONE.
//   The lookahead address is don't-care on that beat.
//  DONE:  done_o=1 for exactly this cycle, then IDLE.
//  sad_valid_i outside WRITE: the beat is dropped (wren_o stays 0) and err_o is set.
//   The FSM is not disturbed.
//  rst during any state: return to IDLE next edge with reset values. No partial done_o pulse.
//  Latency, with beats back-to-back and ready held high:
//   BLOCKS*DEPTH write cycles, +1 read-fill cycle, +DEPTH read cycles, +1 DONE cycle
//   = 130 cycles from the first beat to done_o.
// TESTING
//  1. start, 96 back-to-back beats, rd_ready=1 ->
//     block_o 0/1/2 at beats 0/32/64 with addr_o 0..31 in each; rd_idx_o 0..31 on consecutive
//     cycles; done_o exactly 1 cycle after rd_last_o handshake.
//  2. Beats spaced every 3 cycles (2-cycle gaps) ->
//     addr_o/block_o held during gaps; exactly 96 wren_o pulses; no skipped or repeated address.
//  3. READ with rd_ready toggled 1,0,0,1,... ->
//     rd_idx_o stable while ready=0; 32 handshakes; bank data for index k equals what was
//     written at addr k in each bank.
//  4. sad_valid_i in IDLE and in READ ->
//     wren_o stays 0, err_o=1 and stays set; next start_i clears err_o.
//  5. rst asserted at write beat 40, then at read index 10 ->
//     next cycle busy_o=0, rd_valid_o=0, done_o=0; a fresh start_i runs a full correct frame.
//  6. start_i pulsed during WRITE and during READ -> ignored; counters and state unaffected.

Source files
------------

// File: rtl/ime_sad_16x16_buffer_ctrl_if.sv
// ime_sad_16x16_buffer_ctrl_if: SAD-tree beat, bank control and read handshake signals of the 16x16 SAD buffer sequencer
interface ime_sad_16x16_buffer_ctrl_if #(parameter int ADDR_W = 5);
  logic              start_i;
  logic              sad_valid_i;
  logic              rd_ready_i;
  logic [ADDR_W-1:0] addr_o;
  logic              wren_o;
  logic [1:0]        block_o;
  logic              rd_valid_o;
  logic [ADDR_W-1:0] rd_idx_o;
  logic              rd_last_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  modport master (
    output start_i, sad_valid_i, rd_ready_i,
    input  addr_o, wren_o, block_o, rd_valid_o, rd_idx_o, rd_last_o, busy_o, done_o, err_o
  );
  modport slave (
    input  start_i, sad_valid_i, rd_ready_i,
    output addr_o, wren_o, block_o, rd_valid_o, rd_idx_o, rd_last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/ime_sad_16x16_buffer_ctrl.sv
// ime_sad_16x16_buffer_ctrl: writes BLOCKS banks in turn, then sweeps all banks together to a valid/ready consumer
module ime_sad_16x16_buffer_ctrl #(
  parameter int DEPTH  = 32,
  parameter int BLOCKS = 3,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  ime_sad_16x16_buffer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [1:0]        wr_blk;
  logic              rd_valid, err;
  logic              beat, hs, wr_end, rd_end;
  assign beat   = state == WRITE && bus.sad_valid_i;
  assign hs     = rd_valid && bus.rd_ready_i;
  assign wr_end = beat && wr_idx == LAST && wr_blk == 2'(BLOCKS - 1);
  assign rd_end = hs && rd_idx == LAST;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_idx_o   = rd_idx;
  assign bus.err_o      = err;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state and bank-facing outputs; read address looks ahead one word on a handshake
  always_comb begin
    state_n = state == IDLE  ? (bus.start_i ? WRITE : IDLE) :
              state == WRITE ? (wr_end ? READ : WRITE) :
              state == READ  ? (rd_end ? DONE : READ) : IDLE;
    bus.wren_o    = beat;
    bus.addr_o    = state == WRITE ? wr_idx : state == READ ? (hs ? rd_idx + 1'b1 : rd_idx) : '0;
    bus.block_o   = state == WRITE ? wr_blk : 2'd0;
    bus.rd_last_o = rd_valid && rd_idx == LAST;
    bus.busy_o    = state != IDLE;
    bus.done_o    = state == DONE;
  end
  // write/read counters, read-valid flag and sticky stray-beat error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx   <= '0;
      wr_blk   <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && bus.start_i) begin
        wr_idx <= '0;
        wr_blk <= '0;
        rd_idx <= '0;
      end
      if (beat) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LAST) wr_blk <= wr_blk + 1'b1;
      end
      if (state == READ && !rd_valid) rd_valid <= 1'b1;
      else if (rd_end) rd_valid <= 1'b0;
      if (hs) rd_idx <= rd_idx + 1'b1;
      if (bus.sad_valid_i && state != WRITE) err <= 1'b1;
      else if (state == IDLE && bus.start_i) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ime_sad_16x16_buffer_ctrl.sv
// tb_ime_sad_16x16_buffer_ctrl: frame-level checks of the SAD buffer sequencer against a bank model and beat scoreboard
module tb_ime_sad_16x16_buffer_ctrl;
  localparam int DEPTH = 32, BLOCKS = 3, N = DEPTH * BLOCKS;
  logic clk = 0, rst = 1;
  logic [31:0] wdata = 0;
  logic [31:0] mem [4][DEPTH];
  logic [31:0] bq [4];
  logic [31:0] data_q [N];
  int checks = 0, failures = 0;
  typedef struct {
    int gap; int mode; bit rgap; bit stray; bit poke; int awr; int ard;
    int exp_lat; bit exp_err;
  } vec_t;
  vec_t vt [9];

  ime_sad_16x16_buffer_ctrl_if #(.ADDR_W(5)) bus();
  ime_sad_16x16_buffer_ctrl #(.DEPTH(DEPTH), .BLOCKS(BLOCKS), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // three single-port banks with registered read, driven by the controller's address/enable
  always @(posedge clk) begin
    if (bus.wren_o) mem[bus.block_o][bus.addr_o] <= wdata;
    for (int b = 0; b < 4; b++) bq[b] <= mem[b][bus.addr_o];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int gap, int mode, bit rgap, bit stray, bit poke, int awr, int ard);
    vec_t v;
    v.gap = gap; v.mode = mode; v.rgap = rgap; v.stray = stray; v.poke = poke;
    v.awr = awr; v.ard = ard;
    v.exp_lat = (mode == 0 && !rgap) ? (N - 1) * (gap + 1) + DEPTH + 3 : 0;
    v.exp_err = stray;
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    int n = 0, k = 0, wp = 0, cyc = 0, since, gap, t0 = -1, rc = 0, lat = 0;
    bit fin = 0, st, sad, rdy;
    @(negedge clk); bus.start_i = 1;
    @(negedge clk); bus.start_i = 0;
    #1;
    chk("busy_after_start", int'(bus.busy_o), 1);
    chk("err_cleared_by_start", int'(bus.err_o), 0);
    gap = v.rgap ? int'($urandom_range(0, 3)) : v.gap;
    since = gap;
    while (!fin && cyc < 3000) begin
      sad = 0; st = 0;
      bus.start_i = 0;
      if (n < N && since >= gap) begin sad = 1; wdata = $urandom; end
      if (v.stray && n == N && bus.rd_valid_o && k == 3) begin sad = 1; st = 1; end
      if (v.poke && ((n == 10 && sad) || (bus.rd_valid_o && k == 5))) bus.start_i = 1;
      rdy = v.mode == 0 ? 1'b1 : v.mode == 1 ? (rc % 3 == 0) : 1'($urandom);
      if ((v.awr == n && sad && !st) || (bus.rd_valid_o && k == v.ard)) begin
        rst = 1; sad = 0; bus.start_i = 0;
      end
      bus.sad_valid_i = sad;
      bus.rd_ready_i = rdy;
      #1;
      if (rst) begin
        @(posedge clk); #1;
        rst = 0;
        bus.sad_valid_i = 0;
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_rd_valid", int'(bus.rd_valid_o), 0);
        chk("abort_done", int'(bus.done_o), 0);
        chk("abort_wren", int'(bus.wren_o), 0);
        return;
      end
      if (bus.done_o) begin
        chk("done_reads", k, DEPTH);
        chk("done_beats", n, N);
        lat = cyc - t0 + 1;
        fin = 1;
      end else begin
        chk("wren", int'(bus.wren_o), int'(sad && !st));
        if (bus.wren_o) wp++;
        if (n < N) begin
          chk("wr_addr", int'(bus.addr_o), n % DEPTH);
          chk("wr_block", int'(bus.block_o), n / DEPTH);
          if (sad) begin
            data_q[n] = wdata;
            if (t0 < 0) t0 = cyc;
            n++; since = -1;
            gap = v.rgap ? int'($urandom_range(0, 3)) : v.gap;
          end
        end else begin
          chk("rd_block", int'(bus.block_o), 0);
          if (!bus.rd_valid_o) chk("rd_fill_addr", int'(bus.addr_o), 0);
          else if (!(rdy && k == DEPTH - 1)) chk("rd_addr", int'(bus.addr_o), rdy ? k + 1 : k);
        end
        if (bus.rd_valid_o) begin
          chk("rd_idx", int'(bus.rd_idx_o), k);
          chk("rd_last", int'(bus.rd_last_o), int'(k == DEPTH - 1));
          if (rdy) begin
            for (int b = 0; b < BLOCKS; b++)
              if (bq[b] != data_q[b * DEPTH + k]) begin
                failures++;
                $display("FAIL rd_data bank=%0d idx=%0d actual=%h expected=%h", b, k, bq[b], data_q[b * DEPTH + k]);
              end
            checks++;
            k++;
          end
          rc++;
        end
      end
      since++; cyc++;
      @(negedge clk);
    end
    bus.sad_valid_i = 0;
    bus.start_i = 0;
    if (!fin) begin
      failures++;
      $display("FAIL frame_timeout actual=%0d cycles expected=done", cyc);
      return;
    end
    chk("done_one_cycle", int'(bus.done_o), 0);
    chk("idle_after_done", int'(bus.busy_o), 0);
    chk("err_end", int'(bus.err_o), int'(v.exp_err));
    chk("wren_pulses", wp, N);
    if (v.exp_lat != 0) chk("latency", lat, v.exp_lat);
  endtask

  initial begin
    bus.start_i = 0; bus.sad_valid_i = 0; bus.rd_ready_i = 0;
    vt[0] = mk(0, 0, 0, 0, 0, -1, -1);
    vt[1] = mk(2, 0, 0, 0, 0, -1, -1);
    vt[2] = mk(0, 1, 0, 0, 0, -1, -1);
    vt[3] = mk(0, 0, 0, 1, 0, -1, -1);
    vt[4] = mk(1, 2, 1, 0, 1, -1, -1);
    vt[5] = mk(0, 0, 0, 0, 0, 40, -1);
    vt[6] = mk(0, 1, 0, 0, 0, -1, 10);
    vt[7] = mk(0, 2, 1, 0, 0, -1, -1);
    vt[8] = mk(0, 0, 0, 0, 1, -1, -1);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_rd_valid", int'(bus.rd_valid_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    chk("rst_wren", int'(bus.wren_o), 0);
    chk("rst_addr", int'(bus.addr_o), 0);
    chk("rst_block", int'(bus.block_o), 0);
    chk("rst_rd_last", int'(bus.rd_last_o), 0);
    @(negedge clk);
    bus.sad_valid_i = 1;
    #1;
    chk("idle_stray_wren", int'(bus.wren_o), 0);
    @(negedge clk);
    bus.sad_valid_i = 0;
    #1;
    chk("idle_stray_err", int'(bus.err_o), 1);
    chk("idle_stray_busy", int'(bus.busy_o), 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(bus.err_o), 1);
    for (int i = 0; i < 9; i++) run_frame(vt[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
